// File: rtl/vermibus_memory_pkg.sv
// ============================================================================
// Module   : vermibus_memory_pkg
// Purpose  : Shared Vermibus types, responder state encoding, window decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vermibus_memory_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } bus_state_t;

  // Half-open byte window [base, base + 4*size_words); 33-bit sum avoids wrap at top of map.
  function automatic logic in_window(input word_t address, input word_t base,
                                     input int unsigned size_words);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(size_words) << 2);
    return (address >= base) && ({1'b0, address} < limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vermibus_memory_if.sv
// ============================================================================
// Module   : vermibus_memory_if
// Purpose  : Vermibus request/response bundle between initiator and responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vermibus_memory_if;
  import vermibus_memory_pkg::*;

  logic       valid;
  word_t      address;
  logic [3:0] wstrobe;
  word_t      wdata;
  logic       ready;
  word_t      rdata;

  modport master (output valid, address, wstrobe, wdata, input ready, rdata);
  modport slave  (input valid, address, wstrobe, wdata, output ready, rdata);

endinterface

`default_nettype wire

// File: rtl/vermibus_memory_array.sv
// ============================================================================
// Module   : vermibus_memory_array
// Purpose  : SIZE x 32 RAM, byte-lane writes, synchronous read-before-write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vermibus_memory_array
  import vermibus_memory_pkg::*;
#(
  parameter int SIZE = 1024
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [$clog2(SIZE)-1:0] index,
  input  logic [3:0]              wstrobe,
  input  word_t                   wdata,
  output word_t                   rdata
);

  word_t mem [SIZE];

  // The read register always captures the pre-write word of the same access.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[index];
      for (int i = 0; i < 4; i++) begin
        if (wstrobe[i]) begin
          mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vermibus_memory.sv
// ============================================================================
// Module   : vermibus_memory
// Purpose  : Vermibus RAM responder: window decode, wait states, ready pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vermibus_memory
  import vermibus_memory_pkg::*;
#(
  parameter int    SIZE         = 1024,
  parameter word_t BASE_ADDRESS = 32'h0000_0000,
  parameter int    WAIT_STATES  = 0
) (
  input  logic               clk,
  input  logic               reset,
  vermibus_memory_if.slave   bus
);

  localparam int IDX_W = $clog2(SIZE);

  bus_state_t       state, state_next;
  logic [3:0]       count, count_next;
  logic             hit;
  logic             commit;
  logic             ready;
  logic [IDX_W-1:0] index;
  word_t            array_rdata;

  assign hit   = bus.valid && in_window(bus.address, BASE_ADDRESS, SIZE);
  assign index = bus.address[IDX_W+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // The memory is committed on the same edge that enters RESPOND.
  always_comb begin
    state_next = state;
    count_next = count;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          if (WAIT_STATES == 0) begin
            state_next = RESPOND;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            count_next = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!bus.valid) begin
          state_next = IDLE;
        end else if (count == 4'd0) begin
          state_next = RESPOND;
          commit     = 1'b1;
        end else begin
          count_next = count - 4'd1;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  vermibus_memory_array #(.SIZE(SIZE)) u_array (
    .clk     (clk),
    .en      (commit),
    .index   (index),
    .wstrobe (bus.wstrobe),
    .wdata   (bus.wdata),
    .rdata   (array_rdata)
  );

  // Gating by ready keeps rdata at zero outside the pulse and during reset.
  assign ready     = (state == RESPOND);
  assign bus.ready = ready;
  assign bus.rdata = ready ? array_rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_vermibus_memory.sv
// ============================================================================
// Module   : tb_vermibus_memory
// Purpose  : Directed scoreboard bench over three responder configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vermibus_memory;
  import vermibus_memory_pkg::*;

  typedef struct {
    word_t data;
    bit    known;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  word_t mm [3*1024];
  bit    mk [3*1024];
  exp_t  sb [$];

  always #5 clk = ~clk;

  vermibus_memory_if b0 ();
  vermibus_memory_if b1 ();
  vermibus_memory_if b2 ();

  vermibus_memory #(.SIZE(1024), .BASE_ADDRESS(32'h0000_0000), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .bus(b0.slave));
  vermibus_memory #(.SIZE(1024), .BASE_ADDRESS(32'h0000_0000), .WAIT_STATES(2)) u1 (
    .clk(clk), .reset(reset), .bus(b1.slave));
  vermibus_memory #(.SIZE(256), .BASE_ADDRESS(32'h0000_1000), .WAIT_STATES(3)) u2 (
    .clk(clk), .reset(reset), .bus(b2.slave));

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int ws_of(input int sel);
    return (sel == 0) ? 0 : (sel == 1) ? 2 : 3;
  endfunction

  function automatic bit is_hit(input int sel, input word_t a);
    if (sel == 2) return (a >= 32'h1000) && (a < 32'h1400);
    return a < 32'h1000;
  endfunction

  function automatic int slot(input int sel, input word_t a);
    if (sel == 2) return 2048 + int'(((a - 32'h1000) >> 2) & 32'd255);
    return sel * 1024 + int'((a >> 2) & 32'd1023);
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 0) ? b0.ready : (sel == 1) ? b1.ready : b2.ready;
  endfunction

  function automatic word_t rd(input int sel);
    return (sel == 0) ? b0.rdata : (sel == 1) ? b1.rdata : b2.rdata;
  endfunction

  task automatic drive(input int sel, input logic v, input word_t a,
                       input logic [3:0] s, input word_t d);
    case (sel)
      0:       begin b0.valid = v; b0.address = a; b0.wstrobe = s; b0.wdata = d; end
      1:       begin b1.valid = v; b1.address = a; b1.wstrobe = s; b1.wdata = d; end
      default: begin b2.valid = v; b2.address = a; b2.wstrobe = s; b2.wdata = d; end
    endcase
  endtask

  task automatic model_step(input int sel, input word_t a, input logic [3:0] s, input word_t d);
    int   k;
    exp_t e;
    k       = slot(sel, a);
    e.data  = mm[k];
    e.known = mk[k];
    sb.push_back(e);
    for (int i = 0; i < 4; i++)
      if (s[i]) mm[k][8*i +: 8] = d[8*i +: 8];
    if (s == 4'hF) mk[k] = 1'b1;
  endtask

  // Called at a falling edge; holds valid until ready or the cycle budget runs out.
  task automatic access(input int sel, input word_t a, input logic [3:0] s,
                        input word_t d, input string tag);
    bit   got;
    bit   hit;
    int   lat;
    exp_t e;
    hit = is_hit(sel, a);
    if (hit) model_step(sel, a, s, d);
    drive(sel, 1'b1, a, s, d);
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (rdy(sel)) begin
        got = 1'b1;
        lat = n;
      end else begin
        chk({tag, " idle rdata"}, rd(sel), 32'h0);
      end
    end
    drive(sel, 1'b0, 32'h0, 4'h0, 32'h0);
    if (hit) begin
      e = sb.pop_front();
      chk({tag, " ready seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, 32'(lat), 32'(ws_of(sel) + 1));
      if (got && e.known) chk({tag, " rdata"}, rd(sel), e.data);
      @(negedge clk);
      chk({tag, " pulse width"}, 32'(rdy(sel)), 32'd0);
      chk({tag, " rdata after"}, rd(sel), 32'h0);
    end else begin
      chk({tag, " no ready"}, 32'(got), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    chk("reset ready", 32'(b0.ready), 32'd0);
    chk("reset rdata", b0.rdata, 32'h0);
    chk("reset ready ws3", 32'(b2.ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    access(0, 32'h10, 4'hF, 32'hDEAD_BEEF, "t1 store");
    access(0, 32'h10, 4'h0, 32'h0,         "t1 load");

    access(0, 32'h10, 4'hF, 32'h1122_3344, "t2 init");
    access(0, 32'h10, 4'b0100, 32'h00AA_0000, "t2 byte store");
    access(0, 32'h10, 4'h0, 32'h0,         "t2 readback");
    chk("t2 model", mm[4], 32'h11AA_3344);

    // valid held past the pulse is a fresh request: ready pattern 1,0,1
    drive(0, 1'b1, 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b first ready", 32'(b0.ready), 32'd1);
    chk("b2b first rdata", b0.rdata, 32'h11AA_3344);
    @(negedge clk);
    chk("b2b gap", 32'(b0.ready), 32'd0);
    @(negedge clk);
    chk("b2b second ready", 32'(b0.ready), 32'd1);
    drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);

    access(2, 32'h1000, 4'hF, 32'hAAAA_0001, "t4 store lo");
    access(2, 32'h13FC, 4'hF, 32'hBBBB_00FF, "t4 store hi");
    access(2, 32'h0FFC, 4'hF, 32'hDEAD_0000, "t4 miss below");
    access(2, 32'h1400, 4'hF, 32'hDEAD_0001, "t4 miss above");
    access(2, 32'h13FC, 4'h0, 32'h0,         "t4 read word255");
    access(2, 32'h1000, 4'h0, 32'h0,         "t3 read ws3");

    access(1, 32'h30, 4'hF, 32'h1234_5678, "t5 init");
    drive(1, 1'b1, 32'h30, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("t5 aborted no ready", 32'(b1.ready), 32'd0);
    end
    access(1, 32'h30, 4'h0, 32'h0, "t5 readback");

    access(1, 32'h20, 4'hF, 32'hCAFE_F00D, "t6 init");
    drive(1, 1'b1, 32'h20, 4'hF, 32'h0BAD_BEEF);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6 ready in reset", 32'(b1.ready), 32'd0);
    chk("t6 rdata in reset", b1.rdata, 32'h0);
    chk("t6 state idle", 32'(u1.state), 32'(IDLE));
    drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(1, 32'h20, 4'h0, 32'h0, "t6 readback");

    // reset landing inside a ready pulse must clear the outputs at once
    drive(0, 1'b1, 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    chk("t6 pulse before reset", 32'(b0.ready), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6 pulse killed ready", 32'(b0.ready), 32'd0);
    chk("t6 pulse killed rdata", b0.rdata, 32'h0);
    drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(0, 32'h10, 4'h0, 32'h0, "t6 post reset read");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
